// File: rtl/mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_sequencer_if
// Data-bus handshake between the sequencer (master) and a variable-latency
// memory/bus agent (slave).
//   bus_req   : transaction request, high for every WAIT cycle
//   bus_we    : write strobe, meaningful only while bus_req is high
//   bus_ack   : single-cycle completion pulse from the bus agent
//   bus_rdata : read data, valid in the cycle bus_ack is high
// -----------------------------------------------------------------------------
interface mem_sequencer_if #(
  parameter int Dbits = 32
);
  logic             bus_req;
  logic             bus_we;
  logic             bus_ack;
  logic [Dbits-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/mem_sequencer.sv
// -----------------------------------------------------------------------------
// mem_sequencer
// Sequencing controller between a single-cycle MIPS datapath and a
// variable-latency data bus. Loads/stores freeze the core (dp_enable=0) until
// the bus acknowledges; load data is latched and presented in the COMMIT
// cycle. Also provides debug halt at instruction boundaries and a sticky
// bus-timeout fault.
//
// Parameters:
//   Dbits   : bus / read-data width
//   TIMEOUT : WAIT cycles without ack before FAULT (>= 2)
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   mem_rd_op/mem_wr_op : decoder load/store indication (both = store)
//   werf_in / werf_out  : decoder RF write enable / gated version
//   dp_enable           : datapath PC-update enable
//   bus                 : mem_sequencer_if.master (req/we/ack/rdata)
//   mem_readdata        : data latched on the last ack
//   halt_req / halted   : debug halt request / parked indication
//   fault               : bus timeout, sticky until reset
//   stall_cycles        : stall performance counter
// Build option:
//   MEM_SEQ_PERF_CNT_EN : when defined, stall_cycles counts RUN-with-mem-op
//                         and WAIT cycles (saturating); otherwise tied to 0.
// -----------------------------------------------------------------------------
module mem_sequencer #(
  parameter int Dbits   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd_op,
  input  logic              mem_wr_op,
  input  logic              werf_in,
  output logic              werf_out,
  output logic              dp_enable,
  mem_sequencer_if.master   bus,
  output logic [Dbits-1:0]  mem_readdata,
  input  logic              halt_req,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       stall_cycles
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  // ST_RST is held while reset is asserted so every output reads 0; the first
  // edge after release moves to RUN.
  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_RUN    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [Dbits-1:0] rdata_q;
  logic             latch_s;
  logic             mem_op_s;

  assign mem_op_s = mem_rd_op | mem_wr_op;

  // State, wait counter, latched write type and load-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      if (latch_s) begin
        rdata_q <= bus.bus_rdata;
      end
    end
  end

  // Next-state logic and state/decoder-derived outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    latch_s      = 1'b0;
    dp_enable    = 1'b0;
    werf_out     = 1'b0;
    bus.bus_req  = 1'b0;
    bus.bus_we   = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          // Halt wins over a pending memory op; the instruction re-executes
          // once the halt is released.
          state_d = ST_HALT;
        end else if (mem_op_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          // Capture the access type so bus_we is a pure function of state.
          // Loads and stores both set resolve to a store.
          we_d    = mem_wr_op;
        end else begin
          dp_enable = 1'b1;
          werf_out  = werf_in;
        end
      end
      ST_WAIT: begin
        bus.bus_req = 1'b1;
        bus.bus_we  = we_q;
        if (bus.bus_ack) begin
          latch_s = 1'b1;
          state_d = ST_COMMIT;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_COMMIT: begin
        dp_enable = 1'b1;
        werf_out  = werf_in;
        state_d   = ST_RUN;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_FAULT: begin
        fault   = 1'b1;
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  assign mem_readdata = rdata_q;

`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] stall_q;
  logic        stall_inc_s;

  assign stall_inc_s = (state_q == ST_WAIT) || ((state_q == ST_RUN) && mem_op_s);

  // Saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'd0;
    end else if (stall_inc_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
